mem_responder: RTL

Memory-side responder for the pipeline's load/store port: accepts one data-memory request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns a one-cycle response carrying read data and an error flag. It sits at the far end of the MEM-stage interface, in place of the zero-latency data memory. It backs a byte-addressed, big-endian, 16-bit-word store so the pipeline can be exercised against realistic memory latency.

---
 rtl/mem_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: latency-programmable memory-side responder for the load/store port.
// Backs a big-endian, byte-addressed store of 2^ADDR_W 16-bit words and answers
// each accepted request with a one-cycle response after WAIT wait states.
// Ports: clk, rst (async, active-high); req_valid/req_ready handshake with
// req_write, req_byte, req_addr, req_wdata; resp_valid strobe with resp_rdata, resp_err.
// Optional: define MEM_RESP_ALIGN_CHECK_EN to reject word accesses with addr[0]=1.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic l_write, l_byte;
  logic [15:0] l_addr, l_wdata;
  logic [15:0] mem [2**ADDR_W];
  logic a_write, a_byte, bad, go_resp;
  logic [15:0] a_addr, a_wdata, cur, wr_word, rd_word;
  logic [ADDR_W-1:0] idx;
  // With WAIT=0 the access happens on the accept edge, so the live request
  // stands in for the not-yet-latched copy.
  always_comb begin
    a_write = state == IDLE ? req_write : l_write;
    a_byte  = state == IDLE ? req_byte  : l_byte;
    a_addr  = state == IDLE ? req_addr  : l_addr;
    a_wdata = state == IDLE ? req_wdata : l_wdata;
    idx = a_addr[ADDR_W:1];
    cur = mem[idx];
`ifdef MEM_RESP_ALIGN_CHECK_EN
    bad = (|a_addr[15:ADDR_W+1]) | (!a_byte & a_addr[0]);
`else
    bad = |a_addr[15:ADDR_W+1];
`endif
    // Big-endian: even byte address is the high byte of the word.
    wr_word = !a_byte ? a_wdata : a_addr[0] ? {cur[15:8], a_wdata[7:0]} : {a_wdata[7:0], cur[7:0]};
    rd_word = !a_byte ? cur : {8'h00, a_addr[0] ? cur[7:0] : cur[15:8]};
    go_resp = (state == IDLE && req_valid && WAIT == 0) || (state == WAIT_ST && cnt == 4'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      resp_err <= 1'b0;
      l_write <= 1'b0;
      l_byte <= 1'b0;
      l_addr <= 16'h0000;
      l_wdata <= 16'h0000;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 16'h0000;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          l_write <= req_write;
          l_byte <= req_byte;
          l_addr <= req_addr;
          l_wdata <= req_wdata;
          req_ready <= 1'b0;
          state <= WAIT == 0 ? RESP : WAIT_ST;
          cnt <= 4'(WAIT - 1);
        end
        WAIT_ST: begin
          if (cnt == 4'd0) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (go_resp) begin
        resp_valid <= 1'b1;
        resp_err <= bad;
        resp_rdata <= (bad || a_write) ? 16'h0000 : rd_word;
        if (a_write && !bad) mem[idx] <= wr_word;
      end
    end
  end
endmodule
